// File: rtl/jtag_dmi_req.sv
// DMI request/response stage in the jtag_tck domain: turns the DR update pulse into one
// valid/ready request and tracks op status. Optional abort timer: JTAG_DMI_TIMEOUT_EN.
module jtag_dmi_req #(
  parameter int unsigned ADDR_W         = 7,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              jtag_tck,
  input  logic              jtag_reset,
  input  logic [31:0]       wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              wr_intf,
  input  logic              wr_enab,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_status,
  input  logic              dmi_clr_sticky,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic              dmi_req_wr,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [31:0]       dmi_req_wdata,
  input  logic              dmi_rsp_valid,
  input  logic [31:0]       dmi_rsp_data,
  input  logic              dmi_rsp_err
);

  localparam logic [1:0] StatOk     = 2'b00;
  localparam logic [1:0] StatFailed = 2'b10;
  localparam logic [1:0] StatBusy   = 2'b11;

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e              state_q, state_d;
  logic [1:0]          sticky_q, sticky_d;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [31:0]         req_wdata_q;
  logic                req_wr_q;
  logic [31:0]         rd_data_q;

  logic addr_oob;
  logic latch_req;
  logic rsp_done;
  logic set_failed;
  logic set_busy;
  logic timeout_hit;

  // Any address bit at or above ADDR_W makes the request illegal.
  assign addr_oob = (wr_addr >> ADDR_W) != 32'd0;

`ifdef JTAG_DMI_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;

  assign timeout_hit = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge jtag_tck) begin
    if (jtag_reset || latch_req) begin
      cnt_q <= '0;
    end else if (state_q != StIdle) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge jtag_tck) begin
    if (jtag_reset) begin
      state_q  <= StIdle;
      sticky_q <= StatOk;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    latch_req  = 1'b0;
    rsp_done   = 1'b0;
    set_failed = 1'b0;
    set_busy   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_intf && (sticky_q == StatOk)) begin
          if (addr_oob) begin
            set_failed = 1'b1;
          end else begin
            latch_req = 1'b1;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        if (dmi_req_ready) begin
          state_d = StRsp;
        end
      end
      StRsp: begin
        if (dmi_rsp_valid) begin
          rsp_done   = 1'b1;
          set_failed = dmi_rsp_err;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A new op while one is outstanding is dropped; failed outranks busy.
    if ((state_q != StIdle) && wr_intf && (sticky_q != StatFailed)) begin
      set_busy = 1'b1;
    end

    if (timeout_hit) begin
      state_d    = StIdle;
      rsp_done   = 1'b0;
      set_failed = 1'b1;
    end

    // Set events win over a same-cycle clear.
    sticky_d = sticky_q;
    if (set_failed) begin
      sticky_d = StatFailed;
    end else if (set_busy) begin
      sticky_d = StatBusy;
    end else if (dmi_clr_sticky) begin
      sticky_d = StatOk;
    end
  end

  always_ff @(posedge jtag_tck) begin
    if (jtag_reset) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wr_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (latch_req) begin
        req_addr_q  <= wr_addr[ADDR_W-1:0];
        req_wdata_q <= wr_data;
        req_wr_q    <= wr_enab;
      end
      if (rsp_done && !req_wr_q) begin
        rd_data_q <= dmi_rsp_data;
      end
    end
  end

  always_comb begin
    dmi_req_valid = (state_q == StReq);
    dmi_req_wr    = req_wr_q;
    dmi_req_addr  = req_addr_q;
    dmi_req_wdata = req_wdata_q;
    rd_data       = rd_data_q;
    if (sticky_q != StatOk) begin
      rd_status = sticky_q;
    end else if (state_q != StIdle) begin
      rd_status = StatBusy;
    end else begin
      rd_status = StatOk;
    end
  end

endmodule

// File: tb/tb_jtag_dmi_req.sv
// Bench for jtag_dmi_req: transaction-level model checked every cycle plus directed
// literal expectations. Honours JTAG_DMI_TIMEOUT_EN like the design.
module tb_jtag_dmi_req;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned TO     = 16;
`ifdef JTAG_DMI_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic              jtag_tck = 1'b0;
  logic              jtag_reset = 1'b1;
  logic [31:0]       wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic              wr_intf = 1'b0;
  logic              wr_enab = 1'b0;
  logic [31:0]       rd_data;
  logic [1:0]        rd_status;
  logic              dmi_clr_sticky = 1'b0;
  logic              dmi_req_valid;
  logic              dmi_req_ready = 1'b0;
  logic              dmi_req_wr;
  logic [ADDR_W-1:0] dmi_req_addr;
  logic [31:0]       dmi_req_wdata;
  logic              dmi_rsp_valid = 1'b0;
  logic [31:0]       dmi_rsp_data = '0;
  logic              dmi_rsp_err = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  jtag_dmi_req #(
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .jtag_tck      (jtag_tck),
    .jtag_reset    (jtag_reset),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_intf       (wr_intf),
    .wr_enab       (wr_enab),
    .rd_data       (rd_data),
    .rd_status     (rd_status),
    .dmi_clr_sticky(dmi_clr_sticky),
    .dmi_req_valid (dmi_req_valid),
    .dmi_req_ready (dmi_req_ready),
    .dmi_req_wr    (dmi_req_wr),
    .dmi_req_addr  (dmi_req_addr),
    .dmi_req_wdata (dmi_req_wdata),
    .dmi_rsp_valid (dmi_rsp_valid),
    .dmi_rsp_data  (dmi_rsp_data),
    .dmi_rsp_err   (dmi_rsp_err)
  );

  always #5 jtag_tck = ~jtag_tck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding op, accepted flag, age for the abort timer.
  bit          m_ok = 1'b0;
  bit          m_out, m_acc, m_wr;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [1:0]  m_sticky;
  int          m_age;

  always @(posedge jtag_tck) begin
    bit set_f, set_b;
    set_f = 1'b0;
    set_b = 1'b0;
    if (jtag_reset) begin
      m_out = 0; m_acc = 0; m_wr = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
      m_sticky = 2'd0; m_age = 0;
    end else begin
      if (!m_out) begin
        if (wr_intf && m_sticky == 2'd0) begin
          if (wr_addr >= (32'd1 << ADDR_W)) begin
            set_f = 1'b1;
          end else begin
            m_out = 1; m_acc = 0; m_age = 0;
            m_addr = wr_addr; m_wdata = wr_data; m_wr = wr_enab;
          end
        end
      end else begin
        if (wr_intf && m_sticky != 2'd2) set_b = 1'b1;
        m_age++;
        if (TimeoutOn && m_age == TO) begin
          m_out = 0;
          set_f = 1'b1;
        end else if (!m_acc) begin
          if (dmi_req_ready) m_acc = 1;
        end else if (dmi_rsp_valid) begin
          if (!m_wr) m_rd = dmi_rsp_data;
          if (dmi_rsp_err) set_f = 1'b1;
          m_out = 0;
        end
      end
      if (set_f) m_sticky = 2'd2;
      else if (set_b) m_sticky = 2'd3;
      else if (dmi_clr_sticky) m_sticky = 2'd0;
    end
    m_ok = 1'b1;
  end

  always @(negedge jtag_tck) begin
    if (m_ok) begin
      chk("model valid", 32'(dmi_req_valid), 32'(m_out && !m_acc));
      chk("model wr", 32'(dmi_req_wr), 32'(m_wr));
      chk("model addr", 32'(dmi_req_addr), 32'(m_addr[ADDR_W-1:0]));
      chk("model wdata", dmi_req_wdata, m_wdata);
      chk("model rd_data", rd_data, m_rd);
      chk("model status", 32'(rd_status),
          32'((m_sticky != 2'd0) ? m_sticky : (m_out ? 2'd3 : 2'd0)));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge jtag_tck);
  endtask

  task automatic pulse_req(input logic [31:0] a, input logic [31:0] d, input logic en);
    wr_addr = a; wr_data = d; wr_enab = en; wr_intf = 1'b1;
    cyc();
    wr_intf = 1'b0; wr_enab = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d, input logic err);
    dmi_rsp_valid = 1'b1; dmi_rsp_data = d; dmi_rsp_err = err;
    cyc();
    dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0;
  endtask

  task automatic clr();
    dmi_clr_sticky = 1'b1;
    cyc();
    dmi_clr_sticky = 1'b0;
  endtask

  initial begin
    cyc(2);
    jtag_reset = 1'b0;
    chk("reset status", 32'(rd_status), 32'd0);
    chk("reset valid", 32'(dmi_req_valid), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);

    // Read with ready tied high.
    dmi_req_ready = 1'b1;
    pulse_req(32'h11, 32'h0, 1'b0);
    chk("read valid", 32'(dmi_req_valid), 32'd1);
    chk("read addr", 32'(dmi_req_addr), 32'h11);
    chk("read wr", 32'(dmi_req_wr), 32'd0);
    chk("read status busy", 32'(rd_status), 32'd3);
    cyc();
    chk("read valid drop", 32'(dmi_req_valid), 32'd0);
    cyc();
    rsp(32'hDEADBEEF, 1'b0);
    chk("read rd_data", rd_data, 32'hDEADBEEF);
    chk("read status", 32'(rd_status), 32'd0);

    // Write with ready delayed.
    dmi_req_ready = 1'b0;
    pulse_req(32'h10, 32'h1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("write valid held", 32'(dmi_req_valid), 32'd1);
      chk("write wdata held", dmi_req_wdata, 32'h1);
      chk("write addr held", 32'(dmi_req_addr), 32'h10);
      if (i == 3) dmi_req_ready = 1'b1;
      cyc();
    end
    dmi_req_ready = 1'b0;
    chk("write valid drop", 32'(dmi_req_valid), 32'd0);
    rsp(32'hFFFFFFFF, 1'b0);
    chk("write rd_data kept", rd_data, 32'hDEADBEEF);
    chk("write status", 32'(rd_status), 32'd0);

    // Overlapping op while waiting for the response.
    dmi_req_ready = 1'b1;
    pulse_req(32'h05, 32'h0, 1'b0);
    cyc();
    pulse_req(32'h06, 32'h0, 1'b0);
    chk("overlap no valid", 32'(dmi_req_valid), 32'd0);
    rsp(32'h12345678, 1'b0);
    chk("overlap status", 32'(rd_status), 32'd3);
    chk("overlap rd_data", rd_data, 32'h12345678);
    clr();
    chk("overlap cleared", 32'(rd_status), 32'd0);
    pulse_req(32'h22, 32'h0, 1'b0);
    chk("after clr valid", 32'(dmi_req_valid), 32'd1);
    chk("after clr addr", 32'(dmi_req_addr), 32'h22);
    cyc();
    rsp(32'hA5A5A5A5, 1'b0);
    chk("after clr status", 32'(rd_status), 32'd0);

    // Error response.
    pulse_req(32'h01, 32'h0, 1'b0);
    cyc();
    rsp(32'h0BADF00D, 1'b1);
    chk("err status", 32'(rd_status), 32'd2);
    chk("err rd_data", rd_data, 32'h0BADF00D);
    pulse_req(32'h02, 32'h0, 1'b0);
    chk("err drop valid", 32'(dmi_req_valid), 32'd0);
    chk("err still failed", 32'(rd_status), 32'd2);
    clr();
    chk("err cleared", 32'(rd_status), 32'd0);

    // Address out of range.
    pulse_req(32'h80, 32'h0, 1'b0);
    chk("oob no valid", 32'(dmi_req_valid), 32'd0);
    chk("oob status", 32'(rd_status), 32'd2);
    clr();
    chk("oob cleared", 32'(rd_status), 32'd0);

    // Request that never sees ready.
    dmi_req_ready = 1'b0;
    pulse_req(32'h03, 32'h0, 1'b0);
    cyc(20);
    if (TimeoutOn) begin
      chk("timeout valid", 32'(dmi_req_valid), 32'd0);
      chk("timeout status", 32'(rd_status), 32'd2);
    end else begin
      chk("no timeout valid", 32'(dmi_req_valid), 32'd1);
      chk("no timeout status", 32'(rd_status), 32'd3);
    end
    dmi_req_ready = 1'b1;
    cyc();
    rsp(32'hCAFEF00D, 1'b0);
    if (TimeoutOn) begin
      chk("late rsp status", 32'(rd_status), 32'd2);
      chk("late rsp rd_data", rd_data, 32'h0BADF00D);
    end else begin
      chk("slow rsp status", 32'(rd_status), 32'd0);
      chk("slow rsp rd_data", rd_data, 32'hCAFEF00D);
    end
    clr();

    // Reset in the middle of a response wait.
    pulse_req(32'h04, 32'h0, 1'b0);
    cyc();
    chk("rsp wait status", 32'(rd_status), 32'd3);
    jtag_reset = 1'b1;
    cyc();
    jtag_reset = 1'b0;
    chk("mid reset valid", 32'(dmi_req_valid), 32'd0);
    chk("mid reset status", 32'(rd_status), 32'd0);
    chk("mid reset rd_data", rd_data, 32'd0);
    chk("mid reset addr", 32'(dmi_req_addr), 32'd0);
    rsp(32'h00000077, 1'b0);
    chk("stray rsp rd_data", rd_data, 32'd0);
    chk("stray rsp status", 32'(rd_status), 32'd0);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/jtag_dmi_req.md
Name: jtag_dmi_req

Overview:
Downstream stage of the BSCANE2-based JTAG DMI shift/update block, in the jtag_tck domain. Consumes the one-cycle update pulse {wr_addr, wr_data, wr_intf, wr_enab} and issues one valid/ready request to the debug module. Captures the response and returns rd_data/rd_status, which the upstream block samples on its next Capture-DR. Implements DMI op-status semantics: success, sticky failed, sticky busy.

Parameters:
ADDR_W, 7, DMI address width; wr_addr bits above ADDR_W must be zero.
TIMEOUT_CYCLES, 1024, abort limit in jtag_tck cycles. Used only with JTAG_DMI_TIMEOUT_EN.

Ports:
jtag_tck  in  1  clock.
jtag_reset  in  1  synchronous reset, active-high.
wr_addr  in  32  DMI address from the upstream DR.
wr_data  in  32  DMI write data.
wr_intf  in  1  one-cycle request pulse (op read or write).
wr_enab  in  1  qualifies wr_intf: 1 = write, 0 = read.
rd_data  out  32  last read response data.
rd_status  out  2  00 success, 10 failed, 11 busy.
dmi_clr_sticky  in  1  one-cycle pulse that clears sticky status.
dmi_req_valid  out  1  request valid.
dmi_req_ready  in  1  debug module accepts the request.
dmi_req_wr  out  1  1 = write, 0 = read.
dmi_req_addr  out  ADDR_W  request address.
dmi_req_wdata  out  32  request write data.
dmi_rsp_valid  in  1  one-cycle response strobe.
dmi_rsp_data  in  32  response read data.
dmi_rsp_err  in  1  response error flag.

Behaviour:
- Reset (synchronous, jtag_reset=1): state IDLE. dmi_req_valid=0, dmi_req_wr=0, dmi_req_addr=0, dmi_req_wdata=0, rd_data=0, sticky=00, rd_status=00. Reset mid-transaction aborts with no status update; later dmi_rsp_valid strobes are ignored in IDLE.
- States: IDLE, REQ, RSP.
- IDLE, wr_intf=1:
  - If sticky≠00: drop the request; no change.
  - Else if wr_addr[31:ADDR_W]≠0: drop the request; sticky<=10.
  - Else: latch addr, wdata and wr=wr_enab; go to REQ. dmi_req_valid=1 starting the next cycle (one-cycle latency).
- IDLE, wr_intf=0: no action (this includes the op=nop encoding wr_intf=0/wr_enab=1).
- REQ: valid held high and the payload held stable until dmi_req_ready=1. On valid&ready: valid<=0 on the next edge, go to RSP.
- RSP: wait for dmi_rsp_valid.
  - On the strobe: reads load rd_data<=dmi_rsp_data; writes leave rd_data unchanged.
  - If dmi_rsp_err=1: sticky<=10. Go to IDLE.
- wr_intf=1 in REQ or RSP: request dropped; sticky<=11 unless sticky is already 10 (10 has priority). wr_intf in the same cycle as dmi_rsp_valid in RSP: the completion is processed and the new request still counts as busy.
- rd_status (combinational from registers):
  - sticky if sticky≠00;
  - else 11 while state≠IDLE;
  - else 00.
- dmi_clr_sticky: clears sticky. A set event in the same cycle wins. Does not affect an in-flight transaction.
- At most one outstanding request. No queueing.

Optional Feature:
JTAG_DMI_TIMEOUT_EN:
- Defined: a counter runs in REQ and RSP and is cleared on entering REQ. On reaching TIMEOUT_CYCLES it forces valid<=0, state IDLE and sticky<=10. A late response after abort is ignored.
- Undefined: no counter; the block waits indefinitely in REQ/RSP.

Test Plan:
- Read: wr_intf=1, wr_enab=0, wr_addr=0x11, ready tied high; rsp_valid 3 cycles later with data 0xDEADBEEF -> valid high 1 cycle after the pulse, addr=0x11, wr=0; rd_data=0xDEADBEEF; rd_status 11 during, 00 after.
- Write: wr_enab=1, addr=0x10, data=0x00000001, ready delayed 4 cycles -> valid and payload stable for 4 cycles; rd_data unchanged; final status 00.
- Overlap: second wr_intf while in RSP -> no second dmi_req_valid; rd_status=11 after completion; dmi_clr_sticky -> 00; the next read is then accepted.
- Error: read with dmi_rsp_err=1 -> rd_status=10. Following wr_intf is ignored (no valid) until dmi_clr_sticky.
- Address range: ADDR_W=7, wr_addr=0x80 -> no request, rd_status=10.
- Timeout:
  - Macro defined, TIMEOUT_CYCLES=16, no ready -> valid drops after 16 cycles, rd_status=10, later ready/rsp ignored.
  - Macro undefined -> valid stays high, rd_status=11.
  - Reset asserted mid-RSP -> all outputs at reset values the next cycle.
